// File: rtl/opb_reg_bank_pkg.sv
// Shared types and helpers for the OPB register bank: FSM states, access
// classification and the OPB byte-lane to user-bit mapping.
package opb_reg_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_WAIT
  } state_e;

  typedef enum logic [1:0] {
    K_REG,
    K_STATUS,
    K_COMMIT,
    K_ERR
  } kind_e;

  function automatic int unsigned status_offset(input int unsigned num_regs);
    return num_regs;
  endfunction

  function automatic int unsigned commit_offset(input int unsigned num_regs);
    return num_regs + 1;
  endfunction

  // be[3] is OPB_BE[0], which covers the most significant user byte
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] mask;
    mask = 32'h0;
    for (int unsigned i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/opb_reg_bank_slice.sv
// One control register: byte-masked write, update strobe and, when
// OPB_REG_BANK_SHADOW_EN is defined, a shadow copy published on commit.
module opb_reg_bank_slice #(
  parameter logic [31:0] C_RESET_VAL = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_en,
`ifdef OPB_REG_BANK_SHADOW_EN
  input  logic        i_commit,
`endif
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_mask,
  output logic [31:0] o_active,
  output logic [31:0] o_readback,
  output logic        o_strobe
);

  logic [31:0] r_active;
  logic        r_strobe;

`ifdef OPB_REG_BANK_SHADOW_EN
  logic [31:0] r_shadow;

  // Writes land in the shadow; the active copy only moves on commit
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shadow <= C_RESET_VAL;
      r_active <= C_RESET_VAL;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= i_commit;
      if (i_wr_en) begin
        r_shadow <= (r_shadow & ~i_mask) | (i_wdata & i_mask);
      end
      if (i_commit) begin
        r_active <= r_shadow;
      end
    end
  end

  assign o_readback = r_shadow;
`else
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_active <= C_RESET_VAL;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= i_wr_en;
      if (i_wr_en) begin
        r_active <= (r_active & ~i_mask) | (i_wdata & i_mask);
      end
    end
  end

  assign o_readback = r_active;
`endif

  assign o_active = r_active;
  assign o_strobe = r_strobe;

endmodule

// File: rtl/opb_register_bank.sv
// OPB slave exposing C_NUM_REGS control registers, a sampled status word and,
// with OPB_REG_BANK_SHADOW_EN defined, a commit register for shadowed writes.
module opb_register_bank
  import opb_reg_bank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0108_3000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0108_30FF,
  parameter int unsigned C_OPB_AWIDTH = 32,
  parameter int unsigned C_OPB_DWIDTH = 32,
  parameter int unsigned C_NUM_REGS   = 4,
  parameter logic [31:0] C_RESET_VAL  = 32'h0,
  parameter              C_FAMILY     = "virtex6"
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic [32*C_NUM_REGS-1:0]  user_data_out,
  output logic [C_NUM_REGS-1:0]     user_wr_strobe,
  input  logic [31:0]               user_status_in
);

  localparam int unsigned IDX_W       = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;
  localparam int unsigned FAMILY_BITS = $bits(C_FAMILY);
  localparam bit          CFG_OK      = (C_OPB_DWIDTH == 32) && (FAMILY_BITS > 0);

  state_e             r_state;
  kind_e              r_kind;
  logic               r_rnw;
  logic [IDX_W-1:0]   r_idx;
  logic [31:0]        r_wdata;
  logic [31:0]        r_mask;
  logic [31:0]        r_dbus;
  logic               r_xfer_ack;
  logic               r_err_ack;

  logic [31:0]        w_addr;
  logic [31:0]        w_wdata;
  logic [3:0]         w_be;
  logic [29:0]        w_k;
  logic [IDX_W-1:0]   w_idx;
  logic               w_hit;
  kind_e              w_kind;
  logic [31:0]        w_rdata;
  logic               w_ack_wr;
  logic [C_NUM_REGS-1:0] w_wr_en;
  logic [C_NUM_REGS-1:0] w_strobe;
  logic [31:0]        w_active   [C_NUM_REGS];
  logic [31:0]        w_readback [C_NUM_REGS];

  assign w_addr  = 32'(OPB_ABus);
  assign w_wdata = OPB_DBus;
  assign w_be    = OPB_BE;
  assign w_k     = 30'((w_addr - C_BASEADDR) >> 2);
  assign w_idx   = w_k[IDX_W-1:0];
  assign w_hit   = OPB_select && CFG_OK && (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR);

  // Decode an in-range address into the kind of access it is
  always_comb begin
    w_kind = K_ERR;
    if (w_addr[1:0] != 2'b00) begin
      w_kind = K_ERR;
    end else if (w_k < 30'(C_NUM_REGS)) begin
      w_kind = K_REG;
    end else if (w_k == 30'(status_offset(C_NUM_REGS))) begin
      w_kind = K_STATUS;
`ifdef OPB_REG_BANK_SHADOW_EN
    end else if (w_k == 30'(commit_offset(C_NUM_REGS))) begin
      w_kind = K_COMMIT;
`endif
    end
  end

  always_comb begin
    w_rdata = 32'h0;
    if (w_kind == K_REG) begin
      w_rdata = w_readback[w_idx];
    end else if (w_kind == K_STATUS) begin
      w_rdata = user_status_in;
    end
  end

  // Read data and acks are loaded on the edge entering ACK and cleared on the next
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      r_state    <= ST_IDLE;
      r_kind     <= K_ERR;
      r_rnw      <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= 32'h0;
      r_mask     <= 32'h0;
      r_dbus     <= 32'h0;
      r_xfer_ack <= 1'b0;
      r_err_ack  <= 1'b0;
    end else begin
      r_dbus     <= 32'h0;
      r_xfer_ack <= 1'b0;
      r_err_ack  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            r_state <= ST_ACK;
            r_kind  <= w_kind;
            r_rnw   <= OPB_RNW;
            r_idx   <= w_idx;
            r_wdata <= w_wdata;
            r_mask  <= lane_mask(w_be);
            if (w_kind == K_ERR) begin
              r_err_ack <= 1'b1;
            end else begin
              r_xfer_ack <= 1'b1;
              if (OPB_RNW) begin
                r_dbus <= w_rdata;
              end
            end
          end
        end
        ST_ACK:  r_state <= OPB_seqAddr ? ST_IDLE : ST_WAIT;
        ST_WAIT: if (!OPB_select) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_ack_wr = (r_state == ST_ACK) && !r_rnw;

`ifdef OPB_REG_BANK_SHADOW_EN
  logic w_commit;
  assign w_commit = w_ack_wr && (r_kind == K_COMMIT) && r_wdata[0];
`endif

  for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_reg
    assign w_wr_en[i] = w_ack_wr && (r_kind == K_REG) && (r_idx == IDX_W'(i));

    opb_reg_bank_slice #(
      .C_RESET_VAL (C_RESET_VAL)
    ) u_slice (
      .i_clk      (OPB_Clk),
      .i_rst_n    (OPB_Rst_n),
      .i_wr_en    (w_wr_en[i]),
`ifdef OPB_REG_BANK_SHADOW_EN
      .i_commit   (w_commit),
`endif
      .i_wdata    (r_wdata),
      .i_mask     (r_mask),
      .o_active   (w_active[i]),
      .o_readback (w_readback[i]),
      .o_strobe   (w_strobe[i])
    );

    assign user_data_out[32*i +: 32] = w_active[i];
  end

  assign user_wr_strobe = w_strobe;
  assign Sl_DBus        = r_dbus;
  assign Sl_xferAck     = r_xfer_ack;
  assign Sl_errAck      = r_err_ack;
  assign Sl_retry       = 1'b0;
  assign Sl_toutSup     = 1'b0;

endmodule

// File: tb/tb_opb_register_bank.sv
// Randomised scoreboard bench for opb_register_bank; follows
// OPB_REG_BANK_SHADOW_EN in the reference model when it is defined.
module tb_opb_register_bank;

  localparam int unsigned N    = 4;
  localparam logic [31:0] BASE = 32'h0108_3000;
  localparam logic [31:0] HIGH = 32'h0108_30FF;

  typedef struct {
    bit          err;
    logic [31:0] data;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [31:0]     abus;
  logic [0:3]      be;
  logic [31:0]     dbus;
  logic            rnw;
  logic            sel;
  logic            seq;
  logic [31:0]     sl_dbus;
  logic            xack;
  logic            eack;
  logic            retry;
  logic            tout;
  logic [32*N-1:0] udata;
  logic [N-1:0]    ustrobe;
  logic [31:0]     status;

  logic [31:0] m_active [N];
  logic [31:0] m_shadow [N];
  exp_t        sb_q[$];
  bit          mon_en;
  int          n_tests;
  int          n_fail;

  opb_register_bank dut (
    .OPB_Clk        (clk),
    .OPB_Rst_n      (rst_n),
    .OPB_ABus       (abus),
    .OPB_BE         (be),
    .OPB_DBus       (dbus),
    .OPB_RNW        (rnw),
    .OPB_select     (sel),
    .OPB_seqAddr    (seq),
    .Sl_DBus        (sl_dbus),
    .Sl_xferAck     (xack),
    .Sl_errAck      (eack),
    .Sl_retry       (retry),
    .Sl_toutSup     (tout),
    .user_data_out  (udata),
    .user_wr_strobe (ustrobe),
    .user_status_in (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // 0 = no response, 1 = control reg, 2 = status, 3 = commit, 4 = error
  function automatic int classify(input logic [31:0] a);
    int unsigned k;
    if (a < BASE || a > HIGH) return 0;
    if (a % 4 != 0) return 4;
    k = (a - BASE) / 4;
    if (k < N) return 1;
    if (k == N) return 2;
`ifdef OPB_REG_BANK_SHADOW_EN
    if (k == N + 1) return 3;
`endif
    return 4;
  endfunction

  function automatic logic [32*N-1:0] model_vec();
    logic [32*N-1:0] v;
    for (int i = 0; i < N; i++) v[32*i +: 32] = m_active[i];
    return v;
  endfunction

  function automatic logic [31:0] model_read(input int unsigned k);
`ifdef OPB_REG_BANK_SHADOW_EN
    return m_shadow[k];
`else
    return m_active[k];
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_active[i] = 32'h0;
      m_shadow[i] = 32'h0;
    end
  endtask

  task automatic bus_idle();
    sel = 1'b0; rnw = 1'b0; seq = 1'b0; abus = 32'h0; dbus = 32'h0; be = 4'b0000;
  endtask

  // Scoreboard monitor: every acknowledge consumes one expected response
  always @(negedge clk) begin
    if (mon_en) begin
      if (xack || eack) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_ack: xfer=%0b err=%0b with nothing outstanding (t=%0t)", xack, eack, $time);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("ack_xfer", 128'(xack), 128'(!e.err));
          check("ack_err", 128'(eack), 128'(e.err));
          check("ack_rdata", 128'(sl_dbus), 128'(e.data));
        end
      end else begin
        check("dbus_idle", 128'(sl_dbus), 128'h0);
      end
      check("retry_tout", 128'({retry, tout}), 128'h0);
    end
  end

  task automatic do_xfer(input logic [31:0] a, input bit r, input logic [0:3] b,
                         input logic [31:0] d, input bit s);
    int           cls;
    int unsigned  k;
    exp_t         e;
    logic [N-1:0] exp_strobe;
    logic [31:0]  merged;
    cls = classify(a);
    k = (a - BASE) / 4;
    exp_strobe = '0;
    e.err = (cls == 4);
    e.data = 32'h0;
    if (r && cls == 1) e.data = model_read(k);
    if (r && cls == 2) e.data = status;
    if (cls != 0) sb_q.push_back(e);

    @(posedge clk); #1;
    abus = a; rnw = r; be = b; dbus = d; seq = s; sel = 1'b1;
    @(posedge clk); #1;
    if (cls == 0) begin
      repeat (3) @(posedge clk);
      #1;
      bus_idle();
      check("oor_strobe", 128'(ustrobe), 128'h0);
      check("oor_data", 128'(udata), 128'(model_vec()));
      return;
    end
    check("ack_latency", 128'(xack | eack), 128'h1);
    bus_idle();

    if (!r && cls == 1) begin
      merged = model_read(k);
      for (int j = 0; j < 4; j++) begin
        if (b[j]) merged[31-8*j -: 8] = d[31-8*j -: 8];
      end
`ifdef OPB_REG_BANK_SHADOW_EN
      m_shadow[k] = merged;
`else
      m_active[k] = merged;
      exp_strobe[k] = 1'b1;
`endif
    end
    if (!r && cls == 3 && d[0]) begin
      for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
      exp_strobe = '1;
    end

    @(posedge clk); #1;
    check("wr_strobe", 128'(ustrobe), 128'(exp_strobe));
    check("user_data", 128'(udata), 128'(model_vec()));
    @(posedge clk); #1;
    check("strobe_clear", 128'(ustrobe), 128'h0);
  endtask

  initial begin
    logic [31:0] a;
    bit          r;
    exp_t        e;
    n_tests = 0;
    n_fail  = 0;
    mon_en  = 1'b0;
    rst_n   = 1'b0;
    status  = 32'h0;
    bus_idle();
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("rst_user_data", 128'(udata), 128'h0);
    check("rst_strobe", 128'(ustrobe), 128'h0);
    check("rst_acks", 128'({xack, eack, retry, tout}), 128'h0);
    check("rst_dbus", 128'(sl_dbus), 128'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    do_xfer(32'h0108_3004, 1'b0, 4'b1111, 32'hDEAD_BEEF, 1'b0);
    do_xfer(32'h0108_3000, 1'b0, 4'b1111, 32'h1234_5678, 1'b1);
    do_xfer(32'h0108_3000, 1'b0, 4'b0100, 32'h00AA_0000, 1'b0);
    do_xfer(32'h0108_3000, 1'b1, 4'b1111, 32'h0, 1'b0);
    status = 32'hCAFE_F00D;
    do_xfer(32'h0108_3010, 1'b1, 4'b1111, 32'h0, 1'b0);
    do_xfer(32'h0108_3010, 1'b0, 4'b1111, 32'hFFFF_FFFF, 1'b0);
    do_xfer(32'h0108_3018, 1'b0, 4'b1111, 32'hFFFF_FFFF, 1'b0);
    do_xfer(32'h0108_3018, 1'b1, 4'b1111, 32'h0, 1'b1);
    do_xfer(32'h0108_3002, 1'b0, 4'b1111, 32'hFFFF_FFFF, 1'b0);
    do_xfer(32'h0108_3100, 1'b0, 4'b1111, 32'hFFFF_FFFF, 1'b0);
    do_xfer(32'h0108_2FFC, 1'b1, 4'b1111, 32'h0, 1'b0);
    do_xfer(32'h0108_3000, 1'b0, 4'b1111, 32'h0000_0005, 1'b0);
    do_xfer(32'h0108_3014, 1'b0, 4'b1111, 32'h0000_0001, 1'b0);
    do_xfer(32'h0108_3000, 1'b1, 4'b1111, 32'h0, 1'b0);
    do_xfer(32'h0108_3008, 1'b0, 4'b0000, 32'hFFFF_FFFF, 1'b0);

    for (int t = 0; t < 200; t++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE - 32'(4 * $urandom_range(1, 4));
        1:       a = HIGH + 32'($urandom_range(1, 64));
        2:       a = BASE + 32'($urandom_range(0, 255));
        default: a = BASE + 32'(4 * $urandom_range(0, N + 2));
      endcase
      r = 1'($urandom_range(0, 1));
      if (classify(a) == 3) r = 1'b0;
      status = $urandom;
      do_xfer(a, r, 4'($urandom), $urandom, 1'($urandom_range(0, 1)));
    end

    // Reset landing in the ACK cycle of a write must drop it
    e.err = 1'b0;
    e.data = 32'h0;
    sb_q.push_back(e);
    @(posedge clk); #1;
    abus = BASE + 32'h8; rnw = 1'b0; be = 4'b1111; dbus = 32'hFFFF_FFFF; seq = 1'b0; sel = 1'b1;
    @(posedge clk); #1;
    check("ack_latency_rst", 128'(xack | eack), 128'h1);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("rst_mid_strobe", 128'(ustrobe), 128'h0);
    check("rst_mid_data", 128'(udata), 128'(model_vec()));
    repeat (2) @(posedge clk);
    #1;
    bus_idle();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_data", 128'(udata), 128'(model_vec()));
    do_xfer(32'h0108_3008, 1'b1, 4'b1111, 32'h0, 1'b0);

    check("scoreboard_drained", 128'(sb_q.size()), 128'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
